// File: rtl/avl_text_writer_master.sv
// Avalon-MM master that turns a character stream into byte writes to packed 4-chars-per-word text VRAM,
// with hardware clear-screen and colour-register updates. Optional macro TEXT_INV_EN adds the CHAR_INV input.
module avl_text_writer_master #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter int         CTRL_ADDR = 600,
    parameter logic [7:0] CLR_CHAR  = 8'h20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CHAR_VALID,
    input  logic [7:0]  CHAR_DATA,
`ifdef TEXT_INV_EN
    input  logic        CHAR_INV,
`endif
    output logic        CHAR_READY,
    input  logic        CLR_REQ,
    input  logic        COLOR_REQ,
    input  logic [23:0] COLOR_DATA,
    input  logic        AVL_WAITREQUEST,
    output logic        AVL_WRITE,
    output logic [9:0]  AVL_ADDR,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [31:0] AVL_WRITEDATA,
    output logic [6:0]  CUR_COL,
    output logic [4:0]  CUR_ROW,
    output logic        BUSY
);

    localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
    localparam logic [9:0] CLR_LAST   = 10'(ROWS * COLS / 4 - 1);
    localparam logic [9:0] CTRL_WADDR = 10'(CTRL_ADDR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_CHAR = 2'd1,
        WR_CLR  = 2'd2,
        WR_CTRL = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;
    logic        clr_pend_r, clr_pend_nx_s;
    logic        colr_pend_r, colr_pend_nx_s;
    logic [23:0] color_r, color_nx_s;
    logic [6:0]  col_r, col_nx_s;
    logic [4:0]  row_r, row_nx_s;
    logic [9:0]  cnt_r, cnt_nx_s;
    logic [9:0]  addr_r, addr_nx_s;
    logic [3:0]  be_r, be_nx_s;
    logic [31:0] wdata_r, wdata_nx_s;
    logic        write_r, ready_r, busy_r;
    logic        done_s;
    logic [9:0]  row_w_s, char_addr_s;
    logic [3:0]  char_be_s;
    logic [7:0]  byte_s;
    logic        is_lf_s, is_cr_s;

    function automatic logic [4:0] next_row(input logic [4:0] row);
        return (row == ROW_LAST) ? 5'd0 : row + 5'd1;
    endfunction

`ifdef TEXT_INV_EN
    assign byte_s  = {CHAR_INV, CHAR_DATA[6:0]};
    assign is_lf_s = (CHAR_DATA[6:0] == 7'h0A);
    assign is_cr_s = (CHAR_DATA[6:0] == 7'h0D);
`else
    assign byte_s  = CHAR_DATA;
    assign is_lf_s = (CHAR_DATA == 8'h0A);
    assign is_cr_s = (CHAR_DATA == 8'h0D);
`endif

    // row*20 as shift-and-add keeps the VRAM address path multiplier-free
    assign row_w_s     = {5'd0, row_r};
    assign char_addr_s = (row_w_s << 3'd4) + (row_w_s << 3'd2) + {5'd0, col_r[6:2]};
    assign char_be_s   = 4'b0001 << col_r[1:0];
    assign done_s      = write_r & ~AVL_WAITREQUEST;

    // Next-state and next-output computation for the bus sequencer
    always_comb begin
        state_nx_s     = state_r;
        clr_pend_nx_s  = clr_pend_r | CLR_REQ;
        colr_pend_nx_s = colr_pend_r | COLOR_REQ;
        color_nx_s     = COLOR_REQ ? COLOR_DATA : color_r;
        col_nx_s       = col_r;
        row_nx_s       = row_r;
        cnt_nx_s       = cnt_r;
        addr_nx_s      = addr_r;
        be_nx_s        = be_r;
        wdata_nx_s     = wdata_r;
        case (state_r)
            IDLE: begin
                if (clr_pend_r) begin
                    state_nx_s    = WR_CLR;
                    clr_pend_nx_s = 1'b0;
                    cnt_nx_s      = 10'd0;
                    addr_nx_s     = 10'd0;
                    be_nx_s       = 4'b1111;
                    wdata_nx_s    = {4{CLR_CHAR}};
                end else if (colr_pend_r) begin
                    state_nx_s     = WR_CTRL;
                    colr_pend_nx_s = 1'b0;
                    addr_nx_s      = CTRL_WADDR;
                    be_nx_s        = 4'b1111;
                    wdata_nx_s     = {7'd0, color_nx_s, 1'b0};
                end else if (CHAR_VALID && ready_r) begin
                    if (is_lf_s) begin
                        col_nx_s = 7'd0;
                        row_nx_s = next_row(row_r);
                    end else if (is_cr_s) begin
                        col_nx_s = 7'd0;
                    end else begin
                        state_nx_s = WR_CHAR;
                        addr_nx_s  = char_addr_s;
                        be_nx_s    = char_be_s;
                        wdata_nx_s = {4{byte_s}};
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WR_CHAR: begin
                if (done_s) begin
                    state_nx_s = IDLE;
                    if (col_r == COL_LAST) begin
                        col_nx_s = 7'd0;
                        row_nx_s = next_row(row_r);
                    end else begin
                        col_nx_s = col_r + 7'd1;
                    end
                end else begin
                    state_nx_s = WR_CHAR;
                end
            end
            WR_CLR: begin
                if (done_s && (cnt_r == CLR_LAST)) begin
                    state_nx_s = IDLE;
                    col_nx_s   = 7'd0;
                    row_nx_s   = 5'd0;
                end else if (done_s) begin
                    cnt_nx_s  = cnt_r + 10'd1;
                    addr_nx_s = cnt_r + 10'd1;
                end else begin
                    state_nx_s = WR_CLR;
                end
            end
            WR_CTRL: begin
                if (done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WR_CTRL;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, cursor, pending flags and registered bus/handshake outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r     <= IDLE;
            clr_pend_r  <= 1'b0;
            colr_pend_r <= 1'b0;
            color_r     <= 24'd0;
            col_r       <= 7'd0;
            row_r       <= 5'd0;
            cnt_r       <= 10'd0;
            addr_r      <= 10'd0;
            be_r        <= 4'd0;
            wdata_r     <= 32'd0;
            write_r     <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            clr_pend_r  <= clr_pend_nx_s;
            colr_pend_r <= colr_pend_nx_s;
            color_r     <= color_nx_s;
            col_r       <= col_nx_s;
            row_r       <= row_nx_s;
            cnt_r       <= cnt_nx_s;
            addr_r      <= addr_nx_s;
            be_r        <= be_nx_s;
            wdata_r     <= wdata_nx_s;
            write_r     <= (state_nx_s != IDLE);
            ready_r     <= (state_nx_s == IDLE) && !clr_pend_nx_s && !colr_pend_nx_s;
            busy_r      <= (state_nx_s != IDLE) || clr_pend_nx_s || colr_pend_nx_s;
        end
    end

    assign CHAR_READY    = ready_r;
    assign BUSY          = busy_r;
    assign AVL_WRITE     = write_r;
    assign AVL_ADDR      = addr_r;
    assign AVL_BYTE_EN   = be_r;
    assign AVL_WRITEDATA = wdata_r;
    assign CUR_COL       = col_r;
    assign CUR_ROW       = row_r;

endmodule

// File: tb/tb_avl_text_writer_master.sv
// Directed bench for avl_text_writer_master: a queue-based model of expected bus writes and cursor,
// checked every cycle, plus hand-computed literal expectations.
module tb_avl_text_writer_master;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset, char_valid, char_ready, clr_req, color_req, waitreq;
    logic        avl_write, busy, char_inv;
    logic [7:0]  char_data;
    logic [23:0] color_data;
    logic [9:0]  avl_addr;
    logic [3:0]  avl_be;
    logic [31:0] avl_wdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          m_col, m_row;
    int          n_checks = 0, n_pass = 0;
    int          n_done = 0, hi_cycles = 0, stall_left = 0;
    bit          chk_en = 1'b0;
    logic [9:0]  last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    avl_text_writer_master dut (
        .CLK(clk), .RESET(reset), .CHAR_VALID(char_valid), .CHAR_DATA(char_data),
`ifdef TEXT_INV_EN
        .CHAR_INV(char_inv),
`endif
        .CHAR_READY(char_ready), .CLR_REQ(clr_req), .COLOR_REQ(color_req), .COLOR_DATA(color_data),
        .AVL_WAITREQUEST(waitreq), .AVL_WRITE(avl_write), .AVL_ADDR(avl_addr), .AVL_BYTE_EN(avl_be),
        .AVL_WRITEDATA(avl_wdata), .CUR_COL(cur_col), .CUR_ROW(cur_row), .BUSY(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic void model_char(input logic [7:0] c_in);
        wr_t w;
        logic [7:0] c;
        c = c_in;
`ifdef TEXT_INV_EN
        c = {char_inv, c_in[6:0]};
`endif
        if (c[6:0] == 7'h0A && (c[7] == 1'b0 || c != c_in || 1'b0)) begin
        end
        if (c_in == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (c_in == 8'h0D) begin
            m_col = 0;
        end else begin
            w.addr = 10'(m_row * (COLS / 4) + m_col / 4);
            w.be   = 4'(1 << (m_col % 4));
            w.data = {4{c}};
            exp_q.push_back(w);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end
    endfunction

    function automatic void model_clear();
        wr_t w;
        for (int i = 0; i < ROWS * COLS / 4; i++) begin
            w.addr = 10'(i);
            w.be   = 4'hF;
            w.data = 32'h20202020;
            exp_q.push_back(w);
        end
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic void model_color(input logic [23:0] d);
        wr_t w;
        w.addr = 10'd600;
        w.be   = 4'hF;
        w.data = {7'd0, d, 1'b0};
        exp_q.push_back(w);
    endfunction

    // Slave side and per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (avl_write === 1'b1) begin
                hi_cycles++;
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("wr_addr", {22'd0, avl_addr}, {22'd0, exp_q[0].addr});
                    check("wr_be", {28'd0, avl_be}, {28'd0, exp_q[0].be});
                    check("wr_data", avl_wdata, exp_q[0].data);
                    if (stall_left > 0) begin
                        stall_left--;
                        waitreq = 1'b1;
                    end else begin
                        waitreq   = 1'b0;
                        last_addr = avl_addr;
                        last_be   = avl_be;
                        last_data = avl_wdata;
                        n_done++;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                waitreq = 1'b0;
                if (busy === 1'b0 && exp_q.size() == 0) begin
                    check("idle_col", {25'd0, cur_col}, m_col);
                    check("idle_row", {27'd0, cur_row}, m_row);
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || avl_write !== 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int t;
        char_data  = c;
        char_valid = 1'b1;
        t = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (char_ready === 1'b1) break;
            t++;
        end
        check("char_accepted", {31'd0, char_ready}, 32'd1);
        @(posedge clk); #1;
        char_valid = 1'b0;
        model_char(c);
    endtask

    task automatic pulse_clear();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, {31'd0, avl_write}, 32'd0);
        check({tag, "_addr"}, {22'd0, avl_addr}, 32'd0);
        check({tag, "_be"}, {28'd0, avl_be}, 32'd0);
        check({tag, "_data"}, avl_wdata, 32'd0);
        check({tag, "_ready"}, {31'd0, char_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_col"}, {25'd0, cur_col}, 32'd0);
        check({tag, "_row"}, {27'd0, cur_row}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, cnt, t;
        reset = 1'b0; char_valid = 1'b0; char_data = 8'd0; char_inv = 1'b0;
        clr_req = 1'b0; color_req = 1'b0; color_data = 24'd0; waitreq = 1'b0;
        m_col = 0; m_row = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // 'A' at home
        send_char(8'h41);
        wait_idle();
        check("A_addr", {22'd0, last_addr}, 32'd0);
        check("A_be", {28'd0, last_be}, 32'h1);
        check("A_data", last_data, 32'h41414141);
        check("A_col", {25'd0, cur_col}, 32'd1);
        check("A_row", {27'd0, cur_row}, 32'd0);

        // Walk to (78,2), then 'x' with a 3-cycle stall
        send_char(8'h0A);
        send_char(8'h0A);
        for (int i = 0; i < 78; i++) send_char(8'(8'h61 + i % 26));
        wait_idle();
        check("pre_x_col", {25'd0, cur_col}, 32'd78);
        stall_left = 3; hi_cycles = 0; base = n_done;
        send_char(8'h78);
        wait_idle();
        check("x_addr", {22'd0, last_addr}, 32'd59);
        check("x_be", {28'd0, last_be}, 32'h4);
        check("x_data", last_data, 32'h78787878);
        check("x_hold_cycles", hi_cycles, 32'd4);
        check("x_completions", n_done - base, 32'd1);
        check("x_col", {25'd0, cur_col}, 32'd79);
        check("x_row", {27'd0, cur_row}, 32'd2);

        // Walk to (79,29), 'z' wraps the cursor home
        for (int i = 0; i < 27; i++) send_char(8'h0A);
        for (int i = 0; i < 79; i++) send_char(8'(8'h30 + i % 10));
        send_char(8'h7A);
        wait_idle();
        check("z_addr", {22'd0, last_addr}, 32'd599);
        check("z_be", {28'd0, last_be}, 32'h8);
        check("z_col", {25'd0, cur_col}, 32'd0);
        check("z_row", {27'd0, cur_row}, 32'd0);
        base = n_done;
        send_char(8'h0A);
        @(negedge clk);
        check("lf_write", {31'd0, avl_write}, 32'd0);
        check("lf_ready", {31'd0, char_ready}, 32'd1);
        check("lf_col", {25'd0, cur_col}, 32'd0);
        check("lf_row", {27'd0, cur_row}, 32'd1);
        check("lf_no_write", n_done - base, 32'd0);
        @(posedge clk); #1;

        // CR and a bit-7 code
        send_char(8'h51);
        send_char(8'h0D);
        send_char(8'hB2);
        wait_idle();
        check("b2_data", last_data, 32'hB2B2B2B2);
        check("b2_col", {25'd0, cur_col}, 32'd1);

        // Clear, with a colour request arriving mid-clear
        base = n_done;
        pulse_clear();
        cnt = 0;
        while (cnt < 3000) begin
            @(negedge clk);
            if (cnt == 301) color_req = 1'b0;
            if (busy !== 1'b1) break;
            cnt++;
            if (cnt == 300) begin
                color_req  = 1'b1;
                color_data = 24'hF0000F;
                model_color(24'hF0000F);
            end
        end
        check("clr_busy_cycles", cnt, 32'd603);
        check("clr_writes", n_done - base, 32'd601);
        check("color_addr", {22'd0, last_addr}, 32'd600);
        check("color_be", {28'd0, last_be}, 32'hF);
        check("color_data", last_data, 32'h01E0001E);
        check("clr_col", {25'd0, cur_col}, 32'd0);
        check("clr_row", {27'd0, cur_row}, 32'd0);
        @(posedge clk); #1;

        // Standalone colour update
        color_req = 1'b1; color_data = 24'h123456;
        @(posedge clk); #1;
        color_req = 1'b0;
        model_color(24'h123456);
        wait_idle();
        check("color2_data", last_data, 32'h002468AC);

        // Reset in the middle of a clear
        send_char(8'h51);
        send_char(8'h52);
        wait_idle();
        check("prerst_col", {25'd0, cur_col}, 32'd2);
        base = n_done;
        pulse_clear();
        t = 0;
        while (n_done - base < 300 && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("clr_reached_300", n_done - base, 32'd300);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        m_col = 0; m_row = 0;
        base = n_done;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("post_rst_writes", n_done - base, 32'd0);
        check("post_rst_ready", {31'd0, char_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("model_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
